accumulator_loader: RTL and testbench
=====================================

Name: accumulator_loader

Overview:
- Upstream feeder for the accumulator memory. Takes a host stream of 32-bit operands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the memory's 32-bit `load` bus with one operand per cycle. The memory treats a non-zero `load` as the load strobe, so an idle cycle is `load == 0`.
- Counts delivered operands and monitors the memory's `full` flag. Reports done or error to the testbench/host.

Parameters:
- NUM_VALUES, 1024, number of operands the memory expects before asserting `full`.
- FIFO_DEPTH, 8, input buffer entries (power of two).
- FULL_TIMEOUT, 16, cycles allowed after the last load for `full` to rise.

Ports:
- clk  input  1  sole clock (processor-clock domain of the memory).
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session from IDLE.
- in_data  input  32  host operand.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept in_data this cycle.
- load  output  32  operand to memory; 0 = no load this cycle.
- full  input  1  memory full flag.
- loaded_count  output  11  operands driven onto `load` this session.
- dropped_count  output  11  zero-valued operands discarded (saturates at 2047).
- busy  output  1  high in LOAD or WAIT_FULL.
- done  output  1  session completed successfully (sticky until start/reset).
- error  output  1  protocol failure (sticky until start/reset).

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values: state=IDLE, FIFO empty, load=0, loaded_count=0, dropped_count=0, busy=0, done=0, error=0, timeout counter=0.
- Reset mid-session aborts immediately. `load` is 0 from the cycle after reset is sampled, and FIFO contents are discarded.
- Handshake: a transfer occurs on a rising edge with in_valid && in_ready.
  - in_ready = (fifo_count < FIFO_DEPTH) && (state != DONE_S) && !error.
  - in_ready depends only on registered count; a same-cycle pop does not raise it.
- Zero operands: a transferred in_data == 0 completes the handshake but is not enqueued, and dropped_count increments. Reason: a zero on `load` cannot be distinguished from idle.
- FIFO accepts input in IDLE as well, so the host may prefill before start.
- States:
  - IDLE: load=0. On start, clear counters/done/error and go to LOAD. start is ignored in any other state except DONE_S.
  - LOAD: each cycle with FIFO non-empty and loaded_count < NUM_VALUES, pop the head into the registered `load` and increment loaded_count. Otherwise load=0.
    - Load latency: an operand transferred into an empty FIFO appears on `load` 2 cycles later: enqueue edge, then pop/register edge.
    - When loaded_count reaches NUM_VALUES, go to WAIT_FULL on the same edge as the final pop.
    - `full` sampled high in LOAD sets error and goes to DONE_S (memory filled early).
  - WAIT_FULL: load=0 and the timeout counter increments each cycle.
    - `full` high sets done and goes to DONE_S.
    - Counter reaching FULL_TIMEOUT sets error and goes to DONE_S.
  - DONE_S: load=0 and in_ready=0. Extra host data stays in the FIFO. start returns to LOAD with counters cleared and FIFO retained.
- `load` is registered, never combinational from in_data, and never driven to z.
- FIFO pointers use log2(FIFO_DEPTH)-bit wrap-around plus a separate count. Simultaneous push and pop with count==FIFO_DEPTH cannot occur because in_ready=0.

Test Plan:
- Reset, then prefill 8 operands 1..8 in IDLE (in_ready drops after 8th), pulse start → load shows 1,2,...,8 on consecutive cycles starting the cycle after start is sampled; loaded_count=8.
- NUM_VALUES=4, stream 5,6,7,8 back-to-back, memory model raises full 3 cycles after last load → done=1, error=0, busy=0, state DONE_S, in_ready=0.
- Stream 3,0,0,9 with NUM_VALUES=2 → load shows 3 then 9; dropped_count=2; no cycle drives load=0 as a load.
- NUM_VALUES=4, full never asserts → error=1 exactly FULL_TIMEOUT (16) cycles after entering WAIT_FULL, done=0.
- full forced high after 2 of 4 loads → error=1 next edge, load=0 thereafter.
- Assert reset for one cycle during LOAD with 5 entries buffered → next cycle load=0, loaded_count=0, in_ready=1, FIFO empty (a following start with no input produces no loads).

Source files
------------

// File: rtl/accumulator_loader.sv
// Feeds host operands through a small FIFO onto the accumulator memory load bus,
// counts delivered operands and checks that the memory raises full on time.
module accumulator_loader #(
  parameter int unsigned NUM_VALUES   = 1024,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned FULL_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] load,
  input  logic        full,
  output logic [10:0] loaded_count,
  output logic [10:0] dropped_count,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 11;
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned TW   = $clog2(FULL_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_FULL,
    DONE_S
  } state_t;

  state_t            state;
  logic [DW-1:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNTW-1:0]   fifo_count;
  logic [TW-1:0]     timeout_cnt;
  logic              xfer;
  logic              push;
  logic              pop;

  // Ready depends only on registered state, so a pop in the same cycle never raises it.
  assign in_ready = (fifo_count < CNTW'(FIFO_DEPTH)) && (state != DONE_S) && !error;
  assign xfer     = in_valid && in_ready;
  // A zero operand would be indistinguishable from an idle load cycle, so it is dropped.
  assign push     = xfer && (in_data != '0);
  assign pop      = (state == LOAD) && !full && (fifo_count != '0) &&
                    (loaded_count < CW'(NUM_VALUES));

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; reset discards any buffered operands
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNTW'(1);
        2'b01:   fifo_count <= fifo_count - CNTW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Session control with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      load          <= '0;
      loaded_count  <= '0;
      dropped_count <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      timeout_cnt   <= '0;
    end else begin
      load <= '0;
      if (xfer && (in_data == '0) && (dropped_count != '1)) begin
        dropped_count <= dropped_count + CW'(1);
      end
      case (state)
        IDLE, DONE_S: begin
          if (start) begin
            state         <= LOAD;
            loaded_count  <= '0;
            dropped_count <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            busy          <= 1'b1;
            timeout_cnt   <= '0;
          end
        end
        LOAD: begin
          if (full) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= DONE_S;
          end else if (pop) begin
            load         <= mem[rd_ptr];
            loaded_count <= loaded_count + CW'(1);
            if (loaded_count == CW'(NUM_VALUES - 1)) begin
              state       <= WAIT_FULL;
              timeout_cnt <= '0;
            end
          end
        end
        WAIT_FULL: begin
          if (full) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE_S;
          end else begin
            timeout_cnt <= timeout_cnt + TW'(1);
            if (timeout_cnt == TW'(FULL_TIMEOUT - 1)) begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= DONE_S;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_loader.sv
// Scenario bench for accumulator_loader (NUM_VALUES=4); a load-bus monitor
// pops expected operands from a scoreboard queue filled as stimulus is accepted.
module tb_accumulator_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] load;
  logic        full;
  logic [10:0] loaded_count;
  logic [10:0] dropped_count;
  logic        busy;
  logic        done;
  logic        error;

  int          assertions;
  int          failures;
  logic [31:0] exp_q[$];

  accumulator_loader #(
    .NUM_VALUES  (4),
    .FIFO_DEPTH  (8),
    .FULL_TIMEOUT(16)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .load         (load),
    .full         (full),
    .loaded_count (loaded_count),
    .dropped_count(dropped_count),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every non-zero load must match the oldest accepted operand
  always @(negedge clk) begin
    if (load !== 32'd0) begin
      assertions++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_load: got %0d, required no load", load);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (load !== e) begin
          failures++;
          $display("FAIL sb_load_value: got %0d, required %0d", load, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [31:0] v);
    int n;
    n = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    assertions++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_accept: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end else if (v != 32'd0) begin
      exp_q.push_back(v);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; full = 1'b0;
    repeat (2) @(negedge clk);
    assertions += 7;
    if (load !== 32'd0) begin failures++; $display("FAIL rst_load: got %0d, required 0", load); end
    if (loaded_count !== 11'd0) begin failures++; $display("FAIL rst_loaded_count: got %0d, required 0", loaded_count); end
    if (dropped_count !== 11'd0) begin failures++; $display("FAIL rst_dropped_count: got %0d, required 0", dropped_count); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %0b, required 0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL rst_done: got %0b, required 0", done); end
    if (error !== 1'b0) begin failures++; $display("FAIL rst_error: got %0b, required 0", error); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %0b, required 1", in_ready); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Prefill 1..8 in IDLE, then load the first four and let memory report full
  task automatic test_prefill();
    for (int v = 1; v <= 8; v++) send(32'(v));
    assertions += 2;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL prefill_in_ready: got %0b, required 0", in_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL prefill_busy: got %0b, required 0", busy); end
    pulse_start();
    assertions += 2;
    if (busy !== 1'b1) begin failures++; $display("FAIL prefill_busy_start: got %0b, required 1", busy); end
    if (load !== 32'd0) begin failures++; $display("FAIL prefill_load_start: got %0d, required 0", load); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      assertions++;
      if (load !== 32'(i)) begin failures++; $display("FAIL prefill_load_seq: got %0d, required %0d", load, i); end
    end
    assertions += 2;
    if (loaded_count !== 11'd4) begin failures++; $display("FAIL prefill_loaded_count: got %0d, required 4", loaded_count); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL prefill_in_ready_after: got %0b, required 1", in_ready); end
    repeat (2) @(negedge clk);
    full = 1'b1;
    @(negedge clk);
    full = 1'b0;
    assertions += 4;
    if (done !== 1'b1) begin failures++; $display("FAIL prefill_done: got %0b, required 1", done); end
    if (error !== 1'b0) begin failures++; $display("FAIL prefill_error: got %0b, required 0", error); end
    if (busy !== 1'b0) begin failures++; $display("FAIL prefill_busy_end: got %0b, required 0", busy); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL prefill_in_ready_done: got %0b, required 0", in_ready); end
  endtask

  // Restart from DONE_S drains the retained 5..8, then full never arrives
  task automatic test_timeout();
    int k;
    pulse_start();
    assertions += 2;
    if (loaded_count !== 11'd0) begin failures++; $display("FAIL to_count_clear: got %0d, required 0", loaded_count); end
    if (done !== 1'b0) begin failures++; $display("FAIL to_done_clear: got %0b, required 0", done); end
    for (int i = 5; i <= 8; i++) begin
      @(negedge clk);
      assertions++;
      if (load !== 32'(i)) begin failures++; $display("FAIL to_retained_seq: got %0d, required %0d", load, i); end
    end
    k = 0;
    while (error !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    assertions += 4;
    if (k != 16) begin failures++; $display("FAIL to_cycles: got %0d, required 16", k); end
    if (error !== 1'b1) begin failures++; $display("FAIL to_error: got %0b, required 1", error); end
    if (done !== 1'b0) begin failures++; $display("FAIL to_done: got %0b, required 0", done); end
    if (busy !== 1'b0) begin failures++; $display("FAIL to_busy: got %0b, required 0", busy); end
  endtask

  // Stream 5,6,7,8 back-to-back into an empty FIFO with exact latency checks
  task automatic test_back_to_back();
    logic [31:0] vals [4];
    logic [31:0] e;
    vals = '{32'd5, 32'd6, 32'd7, 32'd8};
    pulse_start();
    assertions++;
    if (error !== 1'b0) begin failures++; $display("FAIL b2b_error_clear: got %0b, required 0", error); end
    for (int i = 0; i < 4; i++) begin
      in_data  = vals[i];
      in_valid = 1'b1;
      assertions++;
      if (in_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_in_ready: got %0b, required 1", in_ready);
      end else begin
        exp_q.push_back(vals[i]);
      end
      @(negedge clk);
      e = (i == 0) ? 32'd0 : vals[i-1];
      assertions++;
      if (load !== e) begin failures++; $display("FAIL b2b_latency: got %0d, required %0d", load, e); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    assertions += 2;
    if (load !== 32'd8) begin failures++; $display("FAIL b2b_last_load: got %0d, required 8", load); end
    if (loaded_count !== 11'd4) begin failures++; $display("FAIL b2b_loaded_count: got %0d, required 4", loaded_count); end
    repeat (2) @(negedge clk);
    full = 1'b1;
    @(negedge clk);
    full = 1'b0;
    assertions += 5;
    if (done !== 1'b1) begin failures++; $display("FAIL b2b_done: got %0b, required 1", done); end
    if (error !== 1'b0) begin failures++; $display("FAIL b2b_error: got %0b, required 0", error); end
    if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy: got %0b, required 0", busy); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_in_ready_done: got %0b, required 0", in_ready); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL b2b_pending: got %0d, required 0", exp_q.size()); end
  endtask

  // Zero operands complete the handshake but never reach the load bus
  task automatic test_zero_drop();
    logic [31:0] vals [6];
    vals = '{32'd3, 32'd0, 32'd0, 32'd9, 32'd10, 32'd11};
    pulse_start();
    for (int i = 0; i < 6; i++) send(vals[i]);
    for (int i = 0; i < 30 && loaded_count != 11'd4; i++) @(negedge clk);
    assertions += 2;
    if (loaded_count !== 11'd4) begin failures++; $display("FAIL zd_loaded_count: got %0d, required 4", loaded_count); end
    if (dropped_count !== 11'd2) begin failures++; $display("FAIL zd_dropped_count: got %0d, required 2", dropped_count); end
    full = 1'b1;
    @(negedge clk);
    full = 1'b0;
    assertions += 2;
    if (done !== 1'b1) begin failures++; $display("FAIL zd_done: got %0b, required 1", done); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL zd_pending: got %0d, required 0", exp_q.size()); end
  endtask

  // Memory reports full after two of four loads
  task automatic test_full_early();
    pulse_start();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'(21 + i);
      exp_q.push_back(32'(21 + i));
      if (i == 3) full = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    full     = 1'b0;
    assertions += 5;
    if (error !== 1'b1) begin failures++; $display("FAIL fe_error: got %0b, required 1", error); end
    if (done !== 1'b0) begin failures++; $display("FAIL fe_done: got %0b, required 0", done); end
    if (load !== 32'd0) begin failures++; $display("FAIL fe_load: got %0d, required 0", load); end
    if (loaded_count !== 11'd2) begin failures++; $display("FAIL fe_loaded_count: got %0d, required 2", loaded_count); end
    if (in_ready !== 1'b0) begin failures++; $display("FAIL fe_in_ready: got %0b, required 0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      assertions++;
      if (load !== 32'd0) begin failures++; $display("FAIL fe_load_after: got %0d, required 0", load); end
    end
    assertions++;
    if (exp_q.size() != 2) begin failures++; $display("FAIL fe_retained: got %0d, required 2", exp_q.size()); end
  endtask

  // Reset in LOAD with five entries buffered aborts and empties the FIFO
  task automatic test_reset_mid();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    for (int v = 31; v <= 35; v++) send(32'(v));
    pulse_start();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    assertions += 4;
    if (load !== 32'd0) begin failures++; $display("FAIL rm_load: got %0d, required 0", load); end
    if (loaded_count !== 11'd0) begin failures++; $display("FAIL rm_loaded_count: got %0d, required 0", loaded_count); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rm_in_ready: got %0b, required 1", in_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy: got %0b, required 0", busy); end
    pulse_start();
    repeat (10) @(negedge clk);
    assertions += 2;
    if (loaded_count !== 11'd0) begin failures++; $display("FAIL rm_no_loads: got %0d, required 0", loaded_count); end
    if (busy !== 1'b1) begin failures++; $display("FAIL rm_busy_restart: got %0b, required 1", busy); end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    reset      = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    full       = 1'b0;
    @(negedge clk);
    test_reset();
    test_prefill();
    test_timeout();
    test_back_to_back();
    test_zero_drop();
    test_full_early();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
